// File: rtl/regfile_access_master_pkg.sv
// Shared types and constants for the regfile access master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_access_pkg;

  // Controller states; INIT is only entered from reset when the clear sweep is enabled.
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_e;

  // Deepest regfile read pipeline the capture strobe can be delayed to match.
  localparam int MAX_READ_LATENCY = 3;

endpackage

// File: rtl/regfile_access_master_if.sv
// Host request/response stream plus regfile port bundle for the access master.
// Latency: n/a (wires only).
// Backpressure: req_ready / rsp_ready carry the valid-ready handshakes.
interface regfile_access_master_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  busy;

  logic [ADDR_WIDTH-1:0] rf_write_address;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic                  rf_write_en;
  logic [ADDR_WIDTH-1:0] rf_read_address;
  logic [DATA_WIDTH-1:0] rf_read_data;

  // The access master itself: serves the host stream, drives the regfile ports.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_read_data,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           rf_write_address, rf_write_data, rf_write_en, rf_read_address
  );

  // The surroundings: host command source plus the regfile.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_read_data,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           rf_write_address, rf_write_data, rf_write_en, rf_read_address
  );

endinterface

// File: rtl/regfile_access_master_rf_read_delay.sv
// Delays a read-start pulse to line up with valid regfile read data.
// Latency: strobe rises LATENCY+1 clocks after start.
// Backpressure: none; one read is outstanding at a time so pulses never overlap.
module rf_read_delay #(
  parameter int LATENCY = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic strobe
);

  logic [LATENCY:0] stage;

  if (LATENCY == 0) begin : g_direct
    // Single stage: strobe in the cycle right after the read is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) stage <= '0;
      else          stage <= start;
    end
  end else begin : g_shift
    // One extra stage per clock of regfile read latency.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) stage <= '0;
      else          stage <= {stage[LATENCY-1:0], start};
    end
  end

  assign strobe = stage[LATENCY];

endmodule

// File: rtl/regfile_access_master.sv
// Turns a valid/ready request stream into regfile write/read cycles, with optional clear sweep.
// Latency: write ack 2 clocks after accept; read response 2+READ_LATENCY clocks after accept.
// Backpressure: one request outstanding; response held until rsp_ready, accept only from IDLE.
module regfile_access_master
  import regfile_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  regfile_access_master_if.master bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  state_e                state;
  state_e                state_nxt;
  logic                  sweep_go;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_write_q;
  logic                  accept;
  logic                  rd_start;
  logic                  rd_strobe;

  assign accept   = (state == ST_IDLE) && bus.req_valid;
  assign rd_start = accept && !bus.req_write;

  rf_read_delay #(.LATENCY(LAT)) u_rd_delay (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (rd_start),
    .strobe (rd_strobe)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  // Next state and all combinational outputs.
  always_comb begin
    state_nxt            = state;
    bus.req_ready        = (state == ST_IDLE);
    bus.busy             = (state != ST_IDLE);
    bus.rsp_valid        = (state == ST_RESP);
    bus.rsp_write        = rsp_write_q;
    bus.rsp_rdata        = rsp_rdata_q;
    bus.rf_read_address  = rd_addr;
    bus.rf_write_en      = 1'b0;
    bus.rf_write_address = wr_addr;
    bus.rf_write_data    = wr_data;
    case (state)
      ST_INIT: begin
        // sweep_go holds off the first sweep write until the clock after reset release,
        // so rf_write_en stays low while reset is asserted.
        bus.rf_write_en      = sweep_go;
        bus.rf_write_address = sweep_cnt;
        bus.rf_write_data    = '0;
        if (sweep_go && (sweep_cnt == LAST_ADDR)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.req_valid) state_nxt = bus.req_write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        bus.rf_write_en = 1'b1;
        state_nxt       = ST_RESP;
      end
      ST_READ: begin
        if (rd_strobe) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clear sweep address; stops at the last entry rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_go  <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      sweep_go <= 1'b1;
      if ((state == ST_INIT) && sweep_go && (sweep_cnt != LAST_ADDR))
        sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Capture request fields on accept and read data on the capture strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      if (accept) begin
        rsp_write_q <= bus.req_write;
        if (bus.req_write) begin
          wr_addr     <= bus.req_addr;
          wr_data     <= bus.req_wdata;
          rsp_rdata_q <= '0;
        end else begin
          rd_addr <= bus.req_addr;
        end
      end
      if ((state == ST_READ) && rd_strobe) rsp_rdata_q <= bus.rf_read_data;
    end
  end

endmodule

// File: tb/tb_regfile_access_master.sv
// Directed bench: DUT A (latency 0, clear sweep) and DUT B (latency 2, no sweep).
// Latency: checks exact response cycles against hand-computed expectations.
// Backpressure: exercises a held response with rsp_ready low.
module tb_regfile_access_master;

  logic clock;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  regfile_access_master_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) ia ();
  regfile_access_master_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) ib ();

  regfile_access_master #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .READ_LATENCY(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ia)
  );

  regfile_access_master #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ib)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Regfile A: zero read latency, preset to FF so the clear sweep is visible.
  logic [7:0] mem_a [4] = '{default: 8'hFF};
  always @(posedge clock) if (ia.rf_write_en) mem_a[ia.rf_write_address] <= ia.rf_write_data;
  assign ia.rf_read_data = mem_a[ia.rf_read_address];

  // Regfile B: two-clock read pipeline.
  logic [7:0] mem_b [4] = '{default: 8'hFF};
  logic [7:0] rb_p1 = 8'h00;
  logic [7:0] rb_p2 = 8'h00;
  always @(posedge clock) begin
    if (ib.rf_write_en) mem_b[ib.rf_write_address] <= ib.rf_write_data;
    rb_p1 <= mem_b[ib.rf_read_address];
    rb_p2 <= rb_p1;
  end
  assign ib.rf_read_data = rb_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request to DUT A with rsp_ready high, starting at a negedge in IDLE.
  task automatic req_a(input logic wr, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rdata);
    ia.req_valid = 1'b1;
    ia.req_write = wr;
    ia.req_addr  = a;
    ia.req_wdata = d;
    @(negedge clock);
    ia.req_valid = 1'b0;
    if (wr) begin
      check("wr_en_t1", ia.rf_write_en, 1);
      check("wr_addr_t1", ia.rf_write_address, a);
      check("wr_data_t1", ia.rf_write_data, d);
    end else begin
      check("rd_no_wr_en", ia.rf_write_en, 0);
      check("rd_addr_t1", ia.rf_read_address, a);
    end
    check("rsp_early", ia.rsp_valid, 0);
    @(negedge clock);
    check("rsp_valid_t2", ia.rsp_valid, 1);
    check("rsp_write_t2", ia.rsp_write, wr);
    check("rsp_rdata_t2", ia.rsp_rdata, exp_rdata);
    check("wr_en_off_t2", ia.rf_write_en, 0);
    @(negedge clock);
    check("ready_t3", ia.req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    ia.req_valid = 1'b0;
    ia.req_write = 1'b0;
    ia.req_addr  = 2'd0;
    ia.req_wdata = 8'h00;
    ia.rsp_ready = 1'b1;
    ib.req_valid = 1'b0;
    ib.req_write = 1'b0;
    ib.req_addr  = 2'd0;
    ib.req_wdata = 8'h00;
    ib.rsp_ready = 1'b1;

    // Reset state.
    @(negedge clock);
    check("rst_wr_en", ia.rf_write_en, 0);
    check("rst_wr_addr", ia.rf_write_address, 0);
    check("rst_wr_data", ia.rf_write_data, 0);
    check("rst_rd_addr", ia.rf_read_address, 0);
    check("rst_rsp_valid", ia.rsp_valid, 0);
    check("rst_rsp_write", ia.rsp_write, 0);
    check("rst_rsp_rdata", ia.rsp_rdata, 0);
    check("rst_busy_a", ia.busy, 1);
    check("rst_ready_a", ia.req_ready, 0);
    check("rst_ready_b", ib.req_ready, 1);
    check("rst_busy_b", ib.busy, 0);

    // Clear sweep: four write cycles to 0..3, then ready.
    reset_n = 1'b1;
    for (int k = 0; k < 5 && !ia.rf_write_en; k++) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check("sweep_en", ia.rf_write_en, 1);
      check("sweep_addr", ia.rf_write_address, i);
      check("sweep_data", ia.rf_write_data, 0);
      check("sweep_ready", ia.req_ready, 0);
      @(negedge clock);
    end
    check("sweep_done_ready", ia.req_ready, 1);
    check("sweep_done_en", ia.rf_write_en, 0);
    check("sweep_done_busy", ia.busy, 0);

    // Every entry reads back as cleared.
    for (int i = 0; i < 4; i++) req_a(1'b0, 2'(i), 8'h00, 8'h00);

    // Write then read the same address.
    req_a(1'b1, 2'd2, 8'h12, 8'h00);
    req_a(1'b0, 2'd2, 8'h00, 8'h12);

    // Back-to-back writes then reads.
    req_a(1'b1, 2'd0, 8'h10, 8'h00);
    req_a(1'b1, 2'd1, 8'h11, 8'h00);
    req_a(1'b1, 2'd2, 8'h12, 8'h00);
    req_a(1'b1, 2'd3, 8'h13, 8'h00);
    req_a(1'b0, 2'd0, 8'h00, 8'h10);
    req_a(1'b0, 2'd1, 8'h00, 8'h11);
    req_a(1'b0, 2'd2, 8'h00, 8'h12);
    req_a(1'b0, 2'd3, 8'h00, 8'h13);

    // Held response: rsp_ready low for five cycles.
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1;
    ia.req_write = 1'b0;
    ia.req_addr  = 2'd1;
    @(negedge clock);
    ia.req_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", ia.rsp_valid, 1);
      check("stall_rdata", ia.rsp_rdata, 8'h11);
      check("stall_write", ia.rsp_write, 0);
      check("stall_ready", ia.req_ready, 0);
      @(negedge clock);
    end
    ia.rsp_ready = 1'b1;
    @(negedge clock);
    check("stall_release_ready", ia.req_ready, 1);
    check("stall_release_valid", ia.rsp_valid, 0);

    // Reset asserted during a write aborts it and restarts the sweep.
    ia.req_valid = 1'b1;
    ia.req_write = 1'b1;
    ia.req_addr  = 2'd3;
    ia.req_wdata = 8'hAA;
    @(negedge clock);
    ia.req_valid = 1'b0;
    check("abort_pre_en", ia.rf_write_en, 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_en", ia.rf_write_en, 0);
    check("abort_rsp_valid", ia.rsp_valid, 0);
    check("abort_busy", ia.busy, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("resweep_en", ia.rf_write_en, 1);
    check("resweep_addr", ia.rf_write_address, 0);
    repeat (4) @(negedge clock);
    check("resweep_ready", ia.req_ready, 1);
    req_a(1'b0, 2'd3, 8'h00, 8'h00);

    // DUT B: write, then read with two-clock regfile latency.
    ib.req_valid = 1'b1;
    ib.req_write = 1'b1;
    ib.req_addr  = 2'd1;
    ib.req_wdata = 8'h5A;
    @(negedge clock);
    ib.req_valid = 1'b0;
    check("b_wr_en", ib.rf_write_en, 1);
    @(negedge clock);
    check("b_wr_rsp_valid", ib.rsp_valid, 1);
    check("b_wr_rsp_write", ib.rsp_write, 1);
    @(negedge clock);
    check("b_wr_ready", ib.req_ready, 1);
    ib.req_valid = 1'b1;
    ib.req_write = 1'b0;
    ib.req_addr  = 2'd1;
    @(negedge clock);
    ib.req_valid = 1'b0;
    check("b_rd_t1", ib.rsp_valid, 0);
    check("b_rd_addr", ib.rf_read_address, 1);
    @(negedge clock);
    check("b_rd_t2", ib.rsp_valid, 0);
    @(negedge clock);
    check("b_rd_t3", ib.rsp_valid, 0);
    check("b_rd_no_wr_en", ib.rf_write_en, 0);
    @(negedge clock);
    check("b_rd_t4_valid", ib.rsp_valid, 1);
    check("b_rd_t4_rdata", ib.rsp_rdata, 8'h5A);
    check("b_rd_t4_write", ib.rsp_write, 0);
    @(negedge clock);
    check("b_rd_ready", ib.req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
